// File: rtl/cache_bus_ctrl_pkg.sv
// Shared bus packet, command op and sequencer state encodings for the cache bus controller.
package cache_bus_ctrl_pkg;

    localparam int unsigned DMA_DATA_WIDTH = 64;

    typedef struct packed {
        logic [31:0]               addr;
        logic [DMA_DATA_WIDTH-1:0] wdata;
        logic                      we;
    } cache_bus_pkt_t;

    typedef enum logic [1:0] {
        OpNone   = 2'b00,
        OpFill   = 2'b01,
        OpWb     = 2'b10,
        OpWbFill = 2'b11
    } bus_op_e;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWb     = 3'd1;
    localparam logic [2:0] StRdReq  = 3'd2;
    localparam logic [2:0] StRdWait = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

endpackage

// File: rtl/cache_bus_ctrl_beat_counter.sv
// Beat counter with synchronous clear and saturating increment; flags the last beat
// and the terminal count.
module bus_beat_counter #(
    parameter int unsigned beats_p     = 4,
    parameter int unsigned cnt_width_p = $clog2(beats_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   incr_i,
    output logic [cnt_width_p-1:0] cnt_o,
    output logic                   last_o,
    output logic                   term_o
);

    localparam logic [cnt_width_p-1:0] LastCnt = cnt_width_p'(beats_p - 1);
    localparam logic [cnt_width_p-1:0] TermCnt = cnt_width_p'(beats_p);

    logic [cnt_width_p-1:0] cnt_q;

    // Clear wins over increment so a final beat and a clear in one cycle lands on zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (incr_i && (cnt_q != TermCnt)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LastCnt);
    assign term_o = (cnt_q == TermCnt);

endmodule

// File: rtl/cache_bus_ctrl.sv
// Block transfer sequencer: splits fill / writeback commands into bus beats and
// assembles returned fill data.
module cache_bus_ctrl
    import cache_bus_ctrl_pkg::*;
#(
    parameter int unsigned block_size_p     = 8,
    parameter int unsigned dma_data_width_p = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_op_i,
    input  logic [31:0]                  req_fill_addr_i,
    input  logic [31:0]                  req_wb_addr_i,
    input  logic [block_size_p*32-1:0]   req_wb_data_i,
    output logic                         resp_valid_o,
    output logic [block_size_p*32-1:0]   fill_data_o,
    output logic                         cb_valid_o,
    input  logic                         cb_yumi_i,
    output cache_bus_pkt_t               cb_pkt_o,
    input  logic                         cb_valid_i,
    input  logic [DMA_DATA_WIDTH-1:0]    cb_data_i
);

    localparam int unsigned beats_lp       = block_size_p / dma_data_width_p;
    localparam int unsigned cnt_width_lp   = $clog2(beats_lp + 1);
    localparam int unsigned block_width_lp = block_size_p * 32;
    localparam logic [31:0] beat_bytes_lp  = 32'(dma_data_width_p * 4);

    logic [2:0]                state_q, state_d;
    bus_op_e                   op_q;
    logic [31:0]               fill_addr_q, wb_addr_q;
    logic [block_width_lp-1:0] wb_data_q, fill_data_q;

    logic                    tx_clr, tx_inc, tx_last, tx_term;
    logic                    rx_clr, rx_inc, rx_last, rx_term;
    logic [cnt_width_lp-1:0] tx_cnt, rx_cnt;
    logic                    accept, rx_capture, rx_write;
    logic [31:0]             beat_off;

    bus_beat_counter #(
        .beats_p     (beats_lp),
        .cnt_width_p (cnt_width_lp)
    ) u_tx_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (tx_clr),
        .incr_i  (tx_inc),
        .cnt_o   (tx_cnt),
        .last_o  (tx_last),
        .term_o  (tx_term)
    );

    bus_beat_counter #(
        .beats_p     (beats_lp),
        .cnt_width_p (cnt_width_lp)
    ) u_rx_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (rx_clr),
        .incr_i  (rx_inc),
        .cnt_o   (rx_cnt),
        .last_o  (rx_last),
        .term_o  (rx_term)
    );

    assign accept   = req_valid_i & req_ready_o;
    assign rx_write = rx_capture & ~rx_term;
    assign rx_inc   = rx_write;
    assign beat_off = 32'(tx_cnt) * beat_bytes_lp;

    always_comb begin
        state_d    = state_q;
        tx_clr     = 1'b0;
        tx_inc     = 1'b0;
        rx_clr     = 1'b0;
        rx_capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    case (bus_op_e'(req_op_i))
                        OpFill:         state_d = StRdReq;
                        OpWb, OpWbFill: state_d = StWb;
                        default:        state_d = StIdle;
                    endcase
                end
            end
            StWb: begin
                if (cb_yumi_i) begin
                    tx_inc = 1'b1;
                    if (tx_last) begin
                        if (op_q == OpWbFill) begin
                            tx_clr  = 1'b1;
                            state_d = StRdReq;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StRdReq: begin
                rx_capture = cb_valid_i;
                if (cb_yumi_i) begin
                    tx_inc = 1'b1;
                    // Responses can all land before the final request is consumed.
                    if (tx_last) begin
                        state_d = (rx_term || (rx_last && cb_valid_i)) ? StDone : StRdWait;
                    end
                end
            end
            StRdWait: begin
                rx_capture = cb_valid_i;
                if (cb_valid_i && rx_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                tx_clr  = 1'b1;
                rx_clr  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            op_q        <= OpNone;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            fill_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q        <= bus_op_e'(req_op_i);
                fill_addr_q <= req_fill_addr_i;
                wb_addr_q   <= req_wb_addr_i;
                wb_data_q   <= req_wb_data_i;
            end
            if (rx_write) begin
                fill_data_q[rx_cnt*DMA_DATA_WIDTH +: DMA_DATA_WIDTH] <= cb_data_i;
            end
        end
    end

    always_comb begin
        cb_valid_o = 1'b0;
        cb_pkt_o   = '0;
        if (state_q == StWb) begin
            cb_valid_o     = ~tx_term;
            cb_pkt_o.we    = 1'b1;
            cb_pkt_o.addr  = wb_addr_q + beat_off;
            cb_pkt_o.wdata = wb_data_q[tx_cnt*DMA_DATA_WIDTH +: DMA_DATA_WIDTH];
        end else if (state_q == StRdReq) begin
            cb_valid_o    = ~tx_term;
            cb_pkt_o.addr = fill_addr_q + beat_off;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StDone);
    assign fill_data_o  = fill_data_q;

endmodule

// File: tb/tb_cache_bus_ctrl.sv
// Directed bench for cache_bus_ctrl: fill, writeback, writeback-then-fill, early
// responses, mid-fill reset and illegal op, all with hand-computed expectations.
module tb_cache_bus_ctrl;
    import cache_bus_ctrl_pkg::*;

    logic                      clk;
    logic                      reset;
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_op;
    logic [31:0]               req_fill_addr;
    logic [31:0]               req_wb_addr;
    logic [255:0]              req_wb_data;
    logic                      resp_valid;
    logic [255:0]              fill_data;
    logic                      cb_valid;
    logic                      cb_yumi;
    cache_bus_pkt_t            cb_pkt;
    logic                      cb_valid_in;
    logic [DMA_DATA_WIDTH-1:0] cb_data;

    int errors;
    int checks;
    cache_bus_pkt_t exp_pkt;
    logic [255:0]   exp_fill;

    cache_bus_ctrl #(
        .block_size_p     (8),
        .dma_data_width_p (2)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_fill_addr_i (req_fill_addr),
        .req_wb_addr_i   (req_wb_addr),
        .req_wb_data_i   (req_wb_data),
        .resp_valid_o    (resp_valid),
        .fill_data_o     (fill_data),
        .cb_valid_o      (cb_valid),
        .cb_yumi_i       (cb_yumi),
        .cb_pkt_o        (cb_pkt),
        .cb_valid_i      (cb_valid_in),
        .cb_data_i       (cb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Eight consecutive 32-bit words base, base+1, ... with word 0 in the LSBs.
    function automatic logic [255:0] words(input logic [31:0] base);
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = base + 32'(w);
        return v;
    endfunction

    function automatic logic [63:0] pair(input logic [31:0] base, input int j);
        return {base + 32'(2*j + 1), base + 32'(2*j)};
    endfunction

    // FILL with yumi tied high and each response two cycles after its yumi.
    task automatic run_fill(input logic [31:0] addr, input logic [31:0] base);
        cache_bus_pkt_t p;
        req_valid     = 1'b1;
        req_op        = 2'b01;
        req_fill_addr = addr;
        check("fill_ready", 256'(req_ready), 256'(1));
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cb_yumi     = (i <= 4);
            cb_valid_in = (i >= 3 && i <= 6);
            cb_data     = cb_valid_in ? pair(base, i - 3) : '0;
            check("fill_valid", 256'(cb_valid), 256'(i <= 4));
            p = '0;
            if (i <= 4) p.addr = addr + 32'(8 * (i - 1));
            check("fill_pkt", 256'(cb_pkt), 256'(p));
            check("fill_resp", 256'(resp_valid), 256'(i == 7));
            check("fill_busy", 256'(req_ready), 256'(i == 8));
            step();
        end
        cb_yumi     = 1'b0;
        cb_valid_in = 1'b0;
        check("fill_data", fill_data, words(base));
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_op        = 2'b00;
        req_fill_addr = '0;
        req_wb_addr   = '0;
        req_wb_data   = '0;
        cb_yumi       = 1'b0;
        cb_valid_in   = 1'b0;
        cb_data       = '0;
        step();
        step();
        check("rst_ready", 256'(req_ready), 256'(1));
        check("rst_resp", 256'(resp_valid), 256'(0));
        check("rst_valid", 256'(cb_valid), 256'(0));
        check("rst_pkt", 256'(cb_pkt), 256'(0));
        check("rst_fill", fill_data, 256'(0));
        reset = 1'b0;
        step();

        run_fill(32'h100, 32'h0);

        // WB with yumi every third cycle; packet must hold while stalled.
        req_valid   = 1'b1;
        req_op      = 2'b10;
        req_wb_addr = 32'h200;
        req_wb_data = words(32'hA0);
        step();
        req_valid   = 1'b0;
        req_wb_data = '0;
        for (int i = 1; i <= 14; i++) begin
            cb_yumi = (i % 3 == 0) && (i <= 12);
            if (i <= 12) begin
                exp_pkt.addr  = 32'h200 + 32'(8 * ((i - 1) / 3));
                exp_pkt.wdata = pair(32'hA0, (i - 1) / 3);
                exp_pkt.we    = 1'b1;
                check("wb_valid", 256'(cb_valid), 256'(1));
                check("wb_pkt", 256'(cb_pkt), 256'(exp_pkt));
            end else begin
                check("wb_idle_valid", 256'(cb_valid), 256'(0));
            end
            check("wb_resp", 256'(resp_valid), 256'(i == 13));
            step();
        end
        cb_yumi = 1'b0;
        check("wb_fill_kept", fill_data, words(32'h0));

        // WB_FILL: four writes then four reads, stray response during writeback.
        req_valid     = 1'b1;
        req_op        = 2'b11;
        req_wb_addr   = 32'h300;
        req_fill_addr = 32'h400;
        req_wb_data   = words(32'hB0);
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            cb_yumi     = (i <= 8);
            cb_valid_in = (i == 2) || (i >= 6 && i <= 9);
            cb_data     = (i == 2) ? 64'hDEAD_BEEF_DEAD_BEEF :
                          (cb_valid_in ? pair(32'hC0, i - 6) : '0);
            exp_pkt = '0;
            if (i <= 4) begin
                exp_pkt.addr  = 32'h300 + 32'(8 * (i - 1));
                exp_pkt.wdata = pair(32'hB0, i - 1);
                exp_pkt.we    = 1'b1;
            end else if (i <= 8) begin
                exp_pkt.addr = 32'h400 + 32'(8 * (i - 5));
            end
            check("wbf_valid", 256'(cb_valid), 256'(i <= 8));
            check("wbf_pkt", 256'(cb_pkt), 256'(exp_pkt));
            check("wbf_resp", 256'(resp_valid), 256'(i == 10));
            if (i == 3) check("wbf_stray", fill_data, words(32'h0));
            step();
        end
        cb_yumi     = 1'b0;
        cb_valid_in = 1'b0;
        check("wbf_fill", fill_data, words(32'hC0));

        // All responses land before the last read yumi; stray response in DONE.
        req_valid     = 1'b1;
        req_op        = 2'b01;
        req_fill_addr = 32'h500;
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cb_yumi     = (i <= 3) || (i == 6);
            cb_valid_in = (i >= 2 && i <= 5) || (i == 7);
            cb_data     = (i == 7) ? 64'hEEEE_EEEE_EEEE_EEEE :
                          (cb_valid_in ? pair(32'hD0, i - 2) : '0);
            check("early_valid", 256'(cb_valid), 256'(i <= 6));
            if (i <= 6) check("early_addr", 256'(cb_pkt.addr),
                              256'(32'h500 + 32'(8 * ((i <= 3) ? i - 1 : 3))));
            check("early_resp", 256'(resp_valid), 256'(i == 7));
            step();
        end
        cb_yumi     = 1'b0;
        cb_valid_in = 1'b0;
        check("early_fill", fill_data, words(32'hD0));

        // Reset after two responses of a fill.
        req_valid     = 1'b1;
        req_op        = 2'b01;
        req_fill_addr = 32'h600;
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cb_yumi     = 1'b1;
            cb_valid_in = (i >= 2);
            cb_data     = pair(32'hF0, i - 2);
            step();
        end
        check("mid_valid", 256'(cb_valid), 256'(1));
        check("mid_partial", fill_data[127:0], {64'h0, 64'h0} | {pair(32'hF0, 1), pair(32'hF0, 0)});
        cb_yumi     = 1'b0;
        cb_valid_in = 1'b0;
        reset       = 1'b1;
        #1;
        check("mid_rst_ready", 256'(req_ready), 256'(1));
        check("mid_rst_resp", 256'(resp_valid), 256'(0));
        check("mid_rst_valid", 256'(cb_valid), 256'(0));
        check("mid_rst_pkt", 256'(cb_pkt), 256'(0));
        check("mid_rst_fill", fill_data, 256'(0));
        step();
        reset       = 1'b0;
        cb_valid_in = 1'b1;
        cb_data     = pair(32'hF4, 0);
        step();
        cb_valid_in = 1'b0;
        check("post_rst_fill", fill_data, 256'(0));
        check("post_rst_ready", 256'(req_ready), 256'(1));
        check("post_rst_valid", 256'(cb_valid), 256'(0));
        run_fill(32'h700, 32'h70);

        // Illegal op is accepted and dropped.
        req_valid = 1'b1;
        req_op    = 2'b00;
        check("ill_ready", 256'(req_ready), 256'(1));
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("ill_valid", 256'(cb_valid), 256'(0));
            check("ill_resp", 256'(resp_valid), 256'(0));
            check("ill_ready_idle", 256'(req_ready), 256'(1));
            step();
        end
        check("ill_fill", fill_data, words(32'h70));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
